// File: rtl/xbar_sw_alloc.sv
// Wormhole switch allocator: per-output round-robin arbitration with packet locks,
// downstream credit counters and sticky protocol/credit error flags.
module xbar_sw_alloc #(
  parameter int P   = 5,
  parameter int B   = 4,
  parameter int P_1 = P - 1,
  parameter int CW  = $clog2(B + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [P*P_1-1:0] dest_req_all,
  input  logic [P-1:0]     hdr_flg_all,
  input  logic [P-1:0]     tail_flg_all,
  input  logic [P-1:0]     credit_in_all,
  output logic [P*P_1-1:0] granted_dest_port_all,
  output logic [P-1:0]     in_read_all,
  output logic [P-1:0]     out_busy_all,
  output logic             credit_err,
  output logic             proto_err
);

  localparam int IW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} out_state_e;

  out_state_e    state_q  [P];
  out_state_e    state_d  [P];
  logic [IW-1:0] owner_q  [P];
  logic [IW-1:0] owner_d  [P];
  logic [IW-1:0] rr_ptr_q [P];
  logic [IW-1:0] rr_ptr_d [P];
  logic [CW-1:0] credit_q [P];
  logic [CW-1:0] credit_d [P];
  logic          credit_err_q, credit_err_d;
  logic          proto_err_q, proto_err_d;

  // req[i][j] / gnt[i][j]: input i towards global output j (diagonal always 0).
  logic [P-1:0]  req [P];
  logic [P-1:0]  gnt [P];

  always_comb begin
    for (int i = 0; i < P; i++) begin
      req[i] = '0;
      for (int j = 0; j < P; j++) begin
        if (j < i)      req[i][j] = dest_req_all[i*P_1 + j];
        else if (j > i) req[i][j] = dest_req_all[i*P_1 + j - 1];
      end
    end
  end

  always_comb begin
    logic          gnt_any;
    logic          has_credit;
    logic [IW-1:0] win;
    int            cand;
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch to hold the old value.
    for (int i = 0; i < P; i++) gnt[i] = '0;
    credit_err_d = credit_err_q;
    proto_err_d  = proto_err_q;
    for (int j = 0; j < P; j++) begin
      state_d[j]  = state_q[j];
      owner_d[j]  = owner_q[j];
      rr_ptr_d[j] = rr_ptr_q[j];
      credit_d[j] = credit_q[j];
      gnt_any     = 1'b0;
      win         = '0;
      cand        = 0;
      has_credit  = (credit_q[j] != '0);

      if (state_q[j] == ST_IDLE) begin
        // Scan from the pointer so the most recent winner has lowest priority.
        for (int k = 0; k < P; k++) begin
          cand = int'(rr_ptr_q[j]) + k;
          if (cand >= P) cand = cand - P;
          if (!gnt_any && req[cand][j] && hdr_flg_all[cand] && has_credit) begin
            gnt_any = 1'b1;
            win     = IW'(cand);
          end
        end
        if (gnt_any) begin
          gnt[win][j] = 1'b1;
          rr_ptr_d[j] = (int'(win) == P - 1) ? '0 : win + 1'b1;
          if (!tail_flg_all[win]) begin
            state_d[j] = ST_LOCKED;
            owner_d[j] = win;
          end
        end
      end else begin
        win = owner_q[j];
        if (req[win][j] && !hdr_flg_all[win] && has_credit) begin
          gnt_any     = 1'b1;
          gnt[win][j] = 1'b1;
          if (tail_flg_all[win]) state_d[j] = ST_IDLE;
        end
      end

      if (credit_in_all[j] && !gnt_any) begin
        if (credit_q[j] == CW'(B)) credit_err_d = 1'b1;
        else                       credit_d[j]  = credit_q[j] + 1'b1;
      end else if (gnt_any && !credit_in_all[j]) begin
        credit_d[j] = credit_q[j] - 1'b1;
      end
    end

    // Owner headers on a locked output and orphan body/tail flits are errors;
    // foreign headers on a locked output simply wait.
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < P; j++) begin
        if (req[i][j]) begin
          if (state_q[j] == ST_LOCKED && int'(owner_q[j]) == i) begin
            if (hdr_flg_all[i]) proto_err_d = 1'b1;
          end else if (!hdr_flg_all[i]) begin
            proto_err_d = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    granted_dest_port_all = '0;
    in_read_all           = '0;
    out_busy_all          = '0;
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < P; j++) begin
        if (j < i)      granted_dest_port_all[i*P_1 + j]     = gnt[i][j] & reset;
        else if (j > i) granted_dest_port_all[i*P_1 + j - 1] = gnt[i][j] & reset;
      end
      in_read_all[i]  = (|gnt[i]) & reset;
      out_busy_all[i] = (state_q[i] == ST_LOCKED);
    end
  end

  assign credit_err = credit_err_q;
  assign proto_err  = proto_err_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order; the small per-output state
  // arrays are control registers, so all of them are reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < P; j++) begin
        state_q[j]  <= ST_IDLE;
        owner_q[j]  <= '0;
        rr_ptr_q[j] <= '0;
        credit_q[j] <= CW'(B);
      end
      credit_err_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      for (int j = 0; j < P; j++) begin
        state_q[j]  <= state_d[j];
        owner_q[j]  <= owner_d[j];
        rr_ptr_q[j] <= rr_ptr_d[j];
        credit_q[j] <= credit_d[j];
      end
      credit_err_q <= credit_err_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_xbar_sw_alloc.sv
// Directed bench for xbar_sw_alloc: single-flit, wormhole lock, round-robin,
// credit exhaustion/overflow and asynchronous reset mid-packet.
module tb_xbar_sw_alloc;

  logic        clk;
  logic        reset;
  logic [19:0] dest_req_all;
  logic [4:0]  hdr_flg_all;
  logic [4:0]  tail_flg_all;
  logic [4:0]  credit_in_all;
  logic [19:0] granted_dest_port_all;
  logic [4:0]  in_read_all;
  logic [4:0]  out_busy_all;
  logic        credit_err;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  xbar_sw_alloc #(.P(5), .B(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .dest_req_all          (dest_req_all),
    .hdr_flg_all           (hdr_flg_all),
    .tail_flg_all          (tail_flg_all),
    .credit_in_all         (credit_in_all),
    .granted_dest_port_all (granted_dest_port_all),
    .in_read_all           (in_read_all),
    .out_busy_all          (out_busy_all),
    .credit_err            (credit_err),
    .proto_err             (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [19:0] req, input logic [4:0] hdr,
                       input logic [4:0] tail, input logic [4:0] cred);
    dest_req_all  = req;
    hdr_flg_all   = hdr;
    tail_flg_all  = tail;
    credit_in_all = cred;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #2;
    total++; if (out_busy_all !== 5'b0) begin bad++; $display("FAIL reset_busy: got %b want 00000", out_busy_all); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err: got %b want 0", credit_err); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    drive(20'h00002, 5'b00001, 5'b00001, 5'b0);
    #1;
    total++; if (granted_dest_port_all !== 20'h0) begin bad++; $display("FAIL reset_grant_forced: got %h want 00000", granted_dest_port_all); end
    total++; if (in_read_all !== 5'b0) begin bad++; $display("FAIL reset_in_read: got %b want 00000", in_read_all); end
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      total++; if (dut.credit_q[j] !== 3'd4) begin bad++; $display("FAIL reset_credit[%0d]: got %0d want 4", j, dut.credit_q[j]); end
    end
  endtask

  task automatic test_single();
    tick();
    drive(20'h00002, 5'b00001, 5'b00001, 5'b0);
    #1;
    total++; if (granted_dest_port_all !== 20'h00002) begin bad++; $display("FAIL single_grant: got %h want 00002", granted_dest_port_all); end
    total++; if (in_read_all !== 5'b00001) begin bad++; $display("FAIL single_in_read: got %b want 00001", in_read_all); end
    tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (out_busy_all[2] !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", out_busy_all[2]); end
    total++; if (dut.credit_q[2] !== 3'd3) begin bad++; $display("FAIL single_credit: got %0d want 3", dut.credit_q[2]); end
    drive(20'h0, 5'b0, 5'b0, 5'b00100);
    tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (dut.credit_q[2] !== 3'd4) begin bad++; $display("FAIL single_credit_back: got %0d want 4", dut.credit_q[2]); end
  endtask

  task automatic test_wormhole();
    // Cycle 1: header from input 1 to output 3; credits returned alongside grants.
    drive(20'h00040, 5'b00010, 5'b00000, 5'b01000);
    #1;
    total++; if (granted_dest_port_all !== 20'h00040) begin bad++; $display("FAIL worm_c1_grant: got %h want 00040", granted_dest_port_all); end
    tick();
    // Cycle 2: body from input 1, competing header from input 4.
    drive(20'h80040, 5'b10000, 5'b10000, 5'b01000);
    #1;
    total++; if (granted_dest_port_all !== 20'h00040) begin bad++; $display("FAIL worm_c2_grant: got %h want 00040", granted_dest_port_all); end
    total++; if (in_read_all !== 5'b00010) begin bad++; $display("FAIL worm_c2_in_read: got %b want 00010", in_read_all); end
    total++; if (out_busy_all[3] !== 1'b1) begin bad++; $display("FAIL worm_c2_busy: got %b want 1", out_busy_all[3]); end
    tick();
    // Cycle 3: tail from input 1, input 4 still waiting.
    drive(20'h80040, 5'b10000, 5'b10010, 5'b01000);
    #1;
    total++; if (granted_dest_port_all !== 20'h00040) begin bad++; $display("FAIL worm_c3_grant: got %h want 00040", granted_dest_port_all); end
    total++; if (out_busy_all[3] !== 1'b1) begin bad++; $display("FAIL worm_c3_busy: got %b want 1", out_busy_all[3]); end
    tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (out_busy_all[3] !== 1'b0) begin bad++; $display("FAIL worm_c4_busy: got %b want 0", out_busy_all[3]); end
    total++; if (granted_dest_port_all !== 20'h0) begin bad++; $display("FAIL worm_c4_grant: got %h want 00000", granted_dest_port_all); end
    tick();
    drive(20'h80000, 5'b10000, 5'b10000, 5'b01000);
    #1;
    total++; if (granted_dest_port_all !== 20'h80000) begin bad++; $display("FAIL worm_c5_grant: got %h want 80000", granted_dest_port_all); end
    total++; if (in_read_all !== 5'b10000) begin bad++; $display("FAIL worm_c5_in_read: got %b want 10000", in_read_all); end
    tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL worm_no_proto_err: got %b want 0", proto_err); end
    total++; if (dut.credit_q[3] !== 3'd4) begin bad++; $display("FAIL worm_credit: got %0d want 4", dut.credit_q[3]); end
  endtask

  task automatic test_rr();
    logic [19:0] exp_g [6];
    logic [4:0]  exp_r [6];
    exp_g = '{20'h00008, 20'h00080, 20'h00800, 20'h00008, 20'h00080, 20'h00800};
    exp_r = '{5'b00001, 5'b00010, 5'b00100, 5'b00001, 5'b00010, 5'b00100};
    drive(20'h00888, 5'b00111, 5'b00111, 5'b10000);
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (granted_dest_port_all !== exp_g[c]) begin bad++; $display("FAIL rr_grant[%0d]: got %h want %h", c, granted_dest_port_all, exp_g[c]); end
      total++; if (in_read_all !== exp_r[c]) begin bad++; $display("FAIL rr_in_read[%0d]: got %b want %b", c, in_read_all, exp_r[c]); end
      tick();
    end
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL rr_credit_err: got %b want 0", credit_err); end
  endtask

  task automatic test_credit();
    drive(20'h00001, 5'b00001, 5'b00001, 5'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (granted_dest_port_all !== 20'h00001) begin bad++; $display("FAIL credit_grant[%0d]: got %h want 00001", c, granted_dest_port_all); end
      tick();
    end
    #1;
    total++; if (granted_dest_port_all !== 20'h0) begin bad++; $display("FAIL credit_stall: got %h want 00000", granted_dest_port_all); end
    total++; if (dut.credit_q[1] !== 3'd0) begin bad++; $display("FAIL credit_zero: got %0d want 0", dut.credit_q[1]); end
    tick();
    drive(20'h00001, 5'b00001, 5'b00001, 5'b00010);
    #1;
    total++; if (granted_dest_port_all !== 20'h0) begin bad++; $display("FAIL credit_same_cycle: got %h want 00000", granted_dest_port_all); end
    tick();
    drive(20'h00001, 5'b00001, 5'b00001, 5'b0);
    #1;
    total++; if (granted_dest_port_all !== 20'h00001) begin bad++; $display("FAIL credit_fifth: got %h want 00001", granted_dest_port_all); end
    tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (dut.credit_q[1] !== 3'd0) begin bad++; $display("FAIL credit_back_zero: got %0d want 0", dut.credit_q[1]); end
    drive(20'h0, 5'b0, 5'b0, 5'b00010);
    for (int c = 0; c < 4; c++) tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (dut.credit_q[1] !== 3'd4) begin bad++; $display("FAIL credit_refill: got %0d want 4", dut.credit_q[1]); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL credit_refill_err: got %b want 0", credit_err); end
  endtask

  task automatic test_simul_overflow();
    drive(20'h01000, 5'b01000, 5'b01000, 5'b00001);
    #1;
    total++; if (granted_dest_port_all !== 20'h01000) begin bad++; $display("FAIL simul_grant: got %h want 01000", granted_dest_port_all); end
    tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (dut.credit_q[0] !== 3'd4) begin bad++; $display("FAIL simul_credit: got %0d want 4", dut.credit_q[0]); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL simul_no_err: got %b want 0", credit_err); end
    drive(20'h0, 5'b0, 5'b0, 5'b00001);
    tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL overflow_err: got %b want 1", credit_err); end
    total++; if (dut.credit_q[0] !== 3'd4) begin bad++; $display("FAIL overflow_hold: got %0d want 4", dut.credit_q[0]); end
    tick();
    tick();
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", credit_err); end
  endtask

  task automatic test_reset_mid();
    drive(20'h00002, 5'b00001, 5'b00000, 5'b0);
    #1;
    total++; if (granted_dest_port_all !== 20'h00002) begin bad++; $display("FAIL mid_hdr_grant: got %h want 00002", granted_dest_port_all); end
    tick();
    drive(20'h00002, 5'b00000, 5'b00000, 5'b0);
    #1;
    total++; if (out_busy_all !== 5'b00100) begin bad++; $display("FAIL mid_locked: got %b want 00100", out_busy_all); end
    total++; if (granted_dest_port_all !== 20'h00002) begin bad++; $display("FAIL mid_body_grant: got %h want 00002", granted_dest_port_all); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_busy_all !== 5'b0) begin bad++; $display("FAIL mid_async_busy: got %b want 00000", out_busy_all); end
    total++; if (granted_dest_port_all !== 20'h0) begin bad++; $display("FAIL mid_async_grant: got %h want 00000", granted_dest_port_all); end
    total++; if (in_read_all !== 5'b0) begin bad++; $display("FAIL mid_async_in_read: got %b want 00000", in_read_all); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL mid_async_credit_err: got %b want 0", credit_err); end
    tick();
    reset = 1'b1;
    #1;
    total++; if (dut.credit_q[2] !== 3'd4) begin bad++; $display("FAIL mid_credit_restored: got %0d want 4", dut.credit_q[2]); end
    total++; if (granted_dest_port_all !== 20'h0) begin bad++; $display("FAIL mid_orphan_grant: got %h want 00000", granted_dest_port_all); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL mid_proto_before: got %b want 0", proto_err); end
    tick();
    drive(20'h0, 5'b0, 5'b0, 5'b0);
    #1;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL mid_proto_err: got %b want 1", proto_err); end
    tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL mid_proto_sticky: got %b want 1", proto_err); end
    total++; if (out_busy_all !== 5'b0) begin bad++; $display("FAIL mid_no_lock: got %b want 00000", out_busy_all); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wormhole();
    test_rr();
    test_credit();
    test_simul_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
